// File: rtl/gate_vec_pkg.sv
// Shared types and constants for the gate-unit self-test sequencer:
// FSM states, result bit positions and the golden truth table.
package gate_vec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int RES_AND  = 0;
    localparam int RES_OR   = 1;
    localparam int RES_NOTA = 2;
    localparam int RES_NAND = 3;
    localparam int RES_NOR  = 4;
    localparam int RES_XOR  = 5;
    localparam int RES_XNOR = 6;

    // Indexed by vector number idx = {a, b}
    localparam logic [6:0] GOLDEN [0:3] = '{7'h5C, 7'h2E, 7'h2A, 7'h43};

    function automatic logic [6:0] golden_res(input logic [1:0] idx);
        return GOLDEN[idx];
    endfunction

endpackage

// File: rtl/gate_vector_sequencer.sv
// Walks a/b through the two-input truth table, holds each vector DWELL cycles,
// and checks the gate unit's seven outputs against the golden table.
module gate_vector_sequencer
    import gate_vec_pkg::*;
#(
    parameter int DWELL = 10,
    parameter int RES_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [RES_W-1:0] res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_vec,
    output logic [2:0]       fail_count
);

    localparam logic [7:0] CNT_RELOAD = 8'(DWELL - 1);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  err_vec_q, err_vec_d;
    logic [2:0]  fail_count_q, fail_count_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_vec_d    = err_vec_q;
        fail_count_d = fail_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = DRIVE;
                    idx_d        = 2'd0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    cnt_d        = CNT_RELOAD;
                    err_vec_d    = 4'd0;
                    fail_count_d = 3'd0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Case-inequality so X/Z on res is scored as a mismatch
                    if (res !== golden_res(idx_q)) begin
                        err_vec_d[idx_q] = 1'b1;
                        fail_count_d     = fail_count_q + 3'd1;
                    end
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        a_d   = idx_d[1];
                        b_d   = idx_d[0];
                        cnt_d = CNT_RELOAD;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_vec_d == 4'd0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= 8'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_vec_q    <= 4'd0;
            fail_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_vec_q    <= err_vec_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_vec    = err_vec_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: two sequencer instances (DWELL=10 and DWELL=1) driving a
// behavioural gate unit with selectable faults.
module tb_gate_vector_sequencer;
    import gate_vec_pkg::*;

    logic clk;
    logic rst_n;
    logic start10, start1;

    logic       a10, b10, busy10, done10, pass10;
    logic [3:0] err10;
    logic [2:0] fc10;
    logic [6:0] res10;

    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] fc1;
    logic [6:0] res1;

    int fault_mode;
    int n_assert;
    int n_fail;
    int done_cnt;
    int done_cyc;

    logic [1:0] ab_tr   [0:63];
    logic       busy_tr [0:63];
    logic [3:0] err_tr  [0:63];

    gate_vector_sequencer #(.DWELL(10), .RES_W(7)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .a(a10), .b(b10), .res(res10),
        .busy(busy10), .done(done10), .pass(pass10), .err_vec(err10), .fail_count(fc10)
    );

    gate_vector_sequencer #(.DWELL(1), .RES_W(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .res(res1),
        .busy(busy1), .done(done1), .pass(pass1), .err_vec(err1), .fail_count(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] gates(input logic ia, input logic ib);
        logic [6:0] r;
        r[RES_AND]  = ia & ib;
        r[RES_OR]   = ia | ib;
        r[RES_NOTA] = ~ia;
        r[RES_NAND] = ~(ia & ib);
        r[RES_NOR]  = ~(ia | ib);
        r[RES_XOR]  = ia ^ ib;
        r[RES_XNOR] = ~(ia ^ ib);
        return r;
    endfunction

    always_comb begin
        res10 = gates(a10, b10);
        case (fault_mode)
            1: res10[RES_OR] = 1'b0;
            2: if (a10 && b10) res10[RES_XNOR] = ~res10[RES_XNOR];
            3: res10[RES_AND] = ~res10[RES_AND];
            default: ;
        endcase
    end

    assign res1 = gates(a1, b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then observe 55 cycles; cycle c is sampled at the falling
    // edge after the c-th rising edge counted from the start edge.
    task automatic sweep10(input int s1, input int s2, input int rst_at);
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk) start10 = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            start10 = (c == s1) || (c == s2);
            ab_tr[c]   = {a10, b10};
            busy_tr[c] = busy10;
            err_tr[c]  = err10;
            if (done10) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_a", 32'(a10), 32'd0);
                check("rst_b", 32'(b10), 32'd0);
                check("rst_busy", 32'(busy10), 32'd0);
                check("rst_err", 32'(err10), 32'd0);
                check("rst_fc", 32'(fc10), 32'd0);
            end
            if (c == rst_at + 2) rst_n = 1'b1;
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        fault_mode = 0;
        start10    = 1'b0;
        start1     = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_a", 32'(a10), 32'd0);
        check("reset_b", 32'(b10), 32'd0);
        check("reset_busy", 32'(busy10), 32'd0);
        check("reset_done", 32'(done10), 32'd0);
        check("reset_pass", 32'(pass10), 32'd0);
        check("reset_err", 32'(err10), 32'd0);
        check("reset_fc", 32'(fc10), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean sweep with DWELL=10
        sweep10(-1, -1, -1);
        check("t1_done_cyc", 32'(done_cyc), 32'd41);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_ab_c1", 32'(ab_tr[1]), 32'd0);
        check("t1_ab_c10", 32'(ab_tr[10]), 32'd0);
        check("t1_ab_c11", 32'(ab_tr[11]), 32'd1);
        check("t1_ab_c20", 32'(ab_tr[20]), 32'd1);
        check("t1_ab_c21", 32'(ab_tr[21]), 32'd2);
        check("t1_ab_c30", 32'(ab_tr[30]), 32'd2);
        check("t1_ab_c31", 32'(ab_tr[31]), 32'd3);
        check("t1_ab_c40", 32'(ab_tr[40]), 32'd3);
        check("t1_busy_c1", 32'(busy_tr[1]), 32'd1);
        check("t1_busy_c40", 32'(busy_tr[40]), 32'd1);
        check("t1_busy_c41", 32'(busy_tr[41]), 32'd0);
        check("t1_pass", 32'(pass10), 32'd1);
        check("t1_err", 32'(err10), 32'd0);
        check("t1_fc", 32'(fc10), 32'd0);
        check("t1_done_low", 32'(done10), 32'd0);

        // OR output stuck at 0, with extra start pulses mid-sweep
        fault_mode = 1;
        sweep10(3, 20, -1);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);
        check("t2_done_cyc", 32'(done_cyc), 32'd41);
        check("t2_err", 32'(err10), 32'b1110);
        check("t2_fc", 32'(fc10), 32'd3);
        check("t2_pass", 32'(pass10), 32'd0);

        // New sweep clears the held failure at the start edge
        fault_mode = 0;
        sweep10(-1, -1, -1);
        check("t3_err_c1", 32'(err_tr[1]), 32'd0);
        check("t3_busy_c1", 32'(busy_tr[1]), 32'd1);
        check("t3_pass", 32'(pass10), 32'd1);
        check("t3_err", 32'(err10), 32'd0);

        // XNOR inverted only on ab=11
        fault_mode = 2;
        sweep10(-1, -1, -1);
        check("t4_err", 32'(err10), 32'b1000);
        check("t4_fc", 32'(fc10), 32'd1);
        check("t4_pass", 32'(pass10), 32'd0);
        repeat (20) @(negedge clk);
        check("t4_err_held", 32'(err10), 32'b1000);
        check("t4_fc_held", 32'(fc10), 32'd1);
        check("t4_pass_held", 32'(pass10), 32'd0);

        // Reset mid-sweep after vector 0 has already failed
        fault_mode = 3;
        sweep10(-1, -1, 15);
        check("t5_err_before_rst", 32'(err_tr[11]), 32'b0001);
        check("t5_done_cnt", 32'(done_cnt), 32'd0);
        check("t5_err_after", 32'(err10), 32'd0);
        check("t5_busy_after", 32'(busy10), 32'd0);
        fault_mode = 0;
        sweep10(-1, -1, -1);
        check("t5_rerun_done_cyc", 32'(done_cyc), 32'd41);
        check("t5_rerun_pass", 32'(pass10), 32'd1);

        // DWELL=1 instance
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk) start1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            ab_tr[c] = {a1, b1};
            if (done1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        check("t6_done_cyc", 32'(done_cyc), 32'd5);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_ab_c1", 32'(ab_tr[1]), 32'd0);
        check("t6_ab_c2", 32'(ab_tr[2]), 32'd1);
        check("t6_ab_c3", 32'(ab_tr[3]), 32'd2);
        check("t6_ab_c4", 32'(ab_tr[4]), 32'd3);
        check("t6_pass", 32'(pass1), 32'd1);
        check("t6_err", 32'(err1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
